// File: rtl/wb_pkg.sv
// Shared definitions for the writeback-control pipeline:
// opcodes, writeback select encodings and the stage bundle.
package wb_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_SEL_MEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_CSR = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel;
    logic       we;
    logic [4:0] rd;
    logic       illegal;
    logic       is_load;
  } wb_bundle_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational decode of an RV32 word into a writeback bundle.
// CSR writeback is produced only when WB_CSR_EN is defined.
module wb_decode
  import wb_pkg::*;
(
  input  logic [31:0] instruction,
  output wb_bundle_t  bundle
);

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic       w_unused;

  assign w_opc    = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_f3     = instruction[14:12];
  assign w_unused = ^{instruction[31:12]};

  // Opcode class -> select/enable; rd == x0 never writes.
  always_comb begin
    bundle    = '0;
    bundle.rd = w_rd;
    unique case (1'b1)
      (w_opc == OPC_LUI) || (w_opc == OPC_AUIPC) ||
      (w_opc == OPC_OPIMM) || (w_opc == OPC_OP): begin
        bundle.sel = WB_SEL_ALU;
        bundle.we  = 1'b1;
      end
      (w_opc == OPC_JAL) || (w_opc == OPC_JALR): begin
        bundle.sel = WB_SEL_PC4;
        bundle.we  = 1'b1;
      end
      (w_opc == OPC_LOAD): begin
        bundle.sel     = WB_SEL_MEM;
        bundle.we      = 1'b1;
        bundle.is_load = 1'b1;
      end
      (w_opc == OPC_BRANCH) || (w_opc == OPC_STORE) ||
      (w_opc == OPC_FENCE): begin
        bundle.we = 1'b0;
      end
      (w_opc == OPC_SYSTEM): begin
`ifdef WB_CSR_EN
        if (w_f3 != 3'b000) begin
          bundle.sel = WB_SEL_CSR;
          bundle.we  = 1'b1;
        end
`else
        bundle.we = 1'b0;
`endif
      end
      default: begin
        bundle.illegal = 1'b1;
      end
    endcase
    if (w_rd == 5'd0) bundle.we = 1'b0;
  end

endmodule

// File: rtl/wb_ctl_pipe.sv
// Writeback-control pipeline: STAGES stall/flush-aware bundle
// registers plus the stage-0 load-use hazard compare.
module wb_ctl_pipe
  import wb_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int WB_SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         instruction,
  input  logic                stall,
  input  logic                flush,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  output logic                ld_hazard,
  output logic                wb_valid,
  output logic [WB_SEL_W-1:0] wb_sel,
  output logic                wb_rf_we,
  output logic [4:0]          wb_rd,
  output logic                wb_illegal
);

  localparam int LAST = STAGES - 1;

  wb_bundle_t w_dec;
  wb_bundle_t w_in;
  wb_bundle_t w_prev [STAGES];
  wb_bundle_t r_stg  [STAGES];

  wb_decode u_dec (
    .instruction (instruction),
    .bundle      (w_dec)
  );

  // Stage inputs: decode feeds stage 0, stage k-1 feeds stage k.
  always_comb begin
    w_in       = w_dec;
    w_in.valid = in_valid & ~flush;
    w_prev[0]  = w_in;
    for (int k = 1; k < STAGES; k++) w_prev[k] = r_stg[k-1];
  end

  // Flush empties younger stages; the last one only obeys stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush && (k != LAST)) r_stg[k].valid <= 1'b0;
        else if (!stall)          r_stg[k]       <= w_prev[k];
      end
    end
  end

  assign wb_valid   = r_stg[LAST].valid;
  assign wb_sel     = WB_SEL_W'(r_stg[LAST].sel);
  assign wb_rf_we   = r_stg[LAST].valid & r_stg[LAST].we;
  assign wb_rd      = r_stg[LAST].rd;
  assign wb_illegal = r_stg[LAST].valid & r_stg[LAST].illegal;

  assign ld_hazard  = r_stg[0].valid & r_stg[0].is_load &
                      (r_stg[0].rd != 5'd0) &
                      ((r_stg[0].rd == rs1) |
                       (r_stg[0].rd == rs2));

endmodule

// File: tb/tb_wb_ctl_pipe.sv
// Randomised bench for wb_ctl_pipe against a position-queue model.
// Honours WB_CSR_EN the same way the design does.
module tb_wb_ctl_pipe;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        ld_hazard;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic        wb_rf_we;
  logic [4:0]  wb_rd;
  logic        wb_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] sel;
    logic       we;
    logic [4:0] rd;
    logic       ill;
    logic       ld;
    int         pos;
  } item_t;

  item_t q[$];

  wb_ctl_pipe #(.STAGES(S), .WB_SEL_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .instruction (instruction),
    .stall       (stall),
    .flush       (flush),
    .rs1         (rs1),
    .rs2         (rs2),
    .ld_hazard   (ld_hazard),
    .wb_valid    (wb_valid),
    .wb_sel      (wb_sel),
    .wb_rf_we    (wb_rf_we),
    .wb_rd       (wb_rd),
    .wb_illegal  (wb_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic item_t ref_dec(input logic [31:0] ins);
    item_t it;
    logic [6:0] opc;
    opc    = ins[6:0];
    it.sel = 2'd0;
    it.we  = 1'b0;
    it.ill = 1'b0;
    it.ld  = 1'b0;
    it.rd  = ins[11:7];
    it.pos = 0;
    case (opc)
      7'h37, 7'h17, 7'h13, 7'h33: begin
        it.sel = 2'd1; it.we = 1'b1;
      end
      7'h6F, 7'h67: begin
        it.sel = 2'd2; it.we = 1'b1;
      end
      7'h03: begin
        it.we = 1'b1; it.ld = 1'b1;
      end
      7'h63, 7'h23, 7'h0F: it.we = 1'b0;
      7'h73: begin
`ifdef WB_CSR_EN
        if (ins[14:12] != 3'd0) begin
          it.sel = 2'd3; it.we = 1'b1;
        end
`endif
      end
      default: it.ill = 1'b1;
    endcase
    if (it.rd == 5'd0) it.we = 1'b0;
    return it;
  endfunction

  task automatic compare_all();
    logic       ev, ew, ei, eh;
    logic [1:0] es;
    logic [4:0] er;
    ev = 0; ew = 0; ei = 0; eh = 0; es = 0; er = 0;
    foreach (q[i]) begin
      if (q[i].pos == S-1) begin
        ev = 1; ew = q[i].we; ei = q[i].ill;
        es = q[i].sel; er = q[i].rd;
      end
      if (q[i].pos == 0 && q[i].ld && q[i].rd != 0 &&
          (q[i].rd == rs1 || q[i].rd == rs2))
        eh = 1;
    end
    check("valid", wb_valid, ev);
    check("we", wb_rf_we, ew);
    check("illegal", wb_illegal, ei);
    check("ld_hazard", ld_hazard, eh);
    if (ev) begin
      check("sel", wb_sel, es);
      check("rd", wb_rd, er);
    end
  endtask

  task automatic model_edge(input logic iv,
                            input logic [31:0] ins,
                            input logic st, input logic fl);
    item_t nq[$];
    item_t it;
    if (fl) begin
      foreach (q[i]) begin
        if (st && q[i].pos == S-1) nq.push_back(q[i]);
        if (!st && q[i].pos == S-2) begin
          it = q[i]; it.pos++; nq.push_back(it);
        end
      end
      q = nq;
    end else if (!st) begin
      foreach (q[i]) begin
        if (q[i].pos < S-1) begin
          it = q[i]; it.pos++; nq.push_back(it);
        end
      end
      if (iv) nq.push_back(ref_dec(ins));
      q = nq;
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ins,
                      input logic st, input logic fl,
                      input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    in_valid = iv; instruction = ins;
    stall = st; flush = fl; rs1 = a; rs2 = b;
    #1;
    compare_all();
    @(posedge clk);
    model_edge(iv, ins, st, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [6:0]  opcs [13];
    logic [31:0] r;
    logic [4:0]  rd;
    opcs = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67,
             7'h03, 7'h63, 7'h23, 7'h0F, 7'h73, 7'h7F,
             7'h0B};
    r  = $urandom;
    rd = ($urandom_range(0, 3) == 0) ? 5'd0
                                      : 5'($urandom_range(1, 7));
    return {r[31:12], rd, opcs[$urandom_range(0, 12)]};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // ADDI x5 appears after S-1 further edges
    step(1'b1, 32'h00500293, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(S-1);
    #1;
    check("addi_valid", wb_valid, 1);
    check("addi_sel", wb_sel, 2'b01);
    check("addi_we", wb_rf_we, 1);
    check("addi_rd", wb_rd, 5'd5);

    // JAL x1 and LW x0
    step(1'b1, 32'h000000EF, 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 32'h00002003, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(S-2);
    #1;
    check("jal_sel", wb_sel, 2'b10);
    check("jal_rd", wb_rd, 5'd1);
    idle(1);
    #1;
    check("lw0_we", wb_rf_we, 0);

    // load-use hazard
    step(1'b1, 32'h00002383, 1'b0, 1'b0, 5'd0, 5'd0);
    rs1 = 5'd7;
    #1;
    check("ldh_hit", ld_hazard, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 5'd7, 5'd0);
    #1;
    check("ldh_gone", ld_hazard, 0);
    step(1'b1, 32'h00002003, 1'b0, 1'b0, 5'd0, 5'd0);
    #1;
    check("ldh_x0", ld_hazard, 0);
    idle(S);

    // illegal opcode and CSRRW x3
    step(1'b1, 32'h0000007F, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(S-1);
    #1;
    check("ill_flag", wb_illegal, 1);
    check("ill_we", wb_rf_we, 0);
    step(1'b1, 32'h000011F3, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(S-1);
    #1;
`ifdef WB_CSR_EN
    check("csr_sel", wb_sel, 2'b11);
    check("csr_we", wb_rf_we, 1);
`else
    check("csr_sel", wb_sel, 2'b00);
    check("csr_we", wb_rf_we, 0);
`endif

    // stall 4 cycles with a full pipe
    for (int i = 0; i < S; i++)
      step(1'b1, 32'h00100093 + (i << 7), 1'b0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h00000113, 1'b1, 1'b0, 5'd0, 5'd0);
    idle(S + 1);

    // stall + flush with a full pipe
    for (int i = 0; i < S; i++)
      step(1'b1, 32'h00100093 + (i << 7), 1'b0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 32'h00000113, 1'b1, 1'b1, 5'd0, 5'd0);
    idle(S + 1);

    // randomised traffic
    for (int i = 0; i < 500; i++)
      step(($urandom_range(0, 3) != 0), rnd_ins(),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 11) == 0),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));

    // asynchronous reset with the pipe full
    for (int i = 0; i < S; i++)
      step(1'b1, 32'h00100093 + (i << 7), 1'b0, 1'b0, 5'd0, 5'd0);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", wb_valid, 0);
    check("rst_async_rd", wb_rd, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(S + 2);
    #1;
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ctl_pipe.md
# wb_ctl_pipe

Parametrised writeback-control pipeline for the rv32 core. Decodes each issued instruction into a writeback bundle: writeback source select, register-file write enable, destination register and illegal flag. The bundle is carried through a configurable number of stall/flush-aware stages so that it arrives at the writeback stage aligned with the datapath. Stage 0 also drives a load-use hazard flag for the issue logic.

## Interface
- `STAGES`, 3: register stages from decode to writeback output; legal range 1..8.
- `WB_SEL_W`, 2: width of the writeback select field.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `instruction` is a real issued instruction this cycle.
- `instruction`  in  32  raw RV32 instruction word.
- `stall`  in  1  hold every stage; no capture, no advance.
- `flush`  in  1  kill all in-flight instructions younger than the writeback output.
- `rs1`, `rs2`  in  5 each  source registers of the instruction now in decode.
- `ld_hazard`  out  1  stage 0 holds a valid load whose rd is nonzero and equals `rs1` or `rs2`.
- `wb_valid`  out  1  output bundle is live.
- `wb_sel`  out  WB_SEL_W  source select: 00 MEM, 01 ALU, 10 PC+4, 11 CSR.
- `wb_rf_we`  out  1  register-file write enable.
- `wb_rd`  out  5  destination register.
- `wb_illegal`  out  1  unrecognised opcode.

## Operation
- Decode by `instruction[6:0]`:
  - LUI 0110111, AUIPC 0010111, OP-IMM 0010011 and OP 0110011 -> sel 01, we 1.
  - JAL 1101111 and JALR 1100111 -> sel 10, we 1.
  - LOAD 0000011 -> sel 00, we 1.
  - BRANCH, STORE, FENCE and SYSTEM -> sel 00, we 0.
  - Any other opcode -> sel 00, we 0, illegal 1.
- No X is ever driven; unused fields are 0.
- `wb_rd` = `instruction[11:7]`.
- `we` is forced to 0 when rd == 0, and whenever the bundle is invalid.
- Each stage holds {valid, sel, we, rd, illegal, is_load}.
- Stage 0 captures `in_valid` plus the decoded bundle; stage k captures stage k-1. The outputs are the last stage.
- `stall`=1: all stages hold, including valid bits.
- `flush`=1: clear valid in every stage except the last on that edge. The new input is also dropped. The last stage still advances normally, so the committing instruction leaves.
- `flush` wins over `stall`. On a stall+flush cycle the younger stages clear and the last stage holds.
- An invalid bundle drives `wb_rf_we`=0 and `wb_illegal`=0 regardless of its stored fields.
- STAGES=1: flush only drops the incoming instruction.

## Timing
- Reset values: all valid bits, `wb_valid`, `wb_sel`, `wb_rf_we`, `wb_rd`, `wb_illegal` and `ld_hazard` are 0.
- Reset asserted mid-operation clears every stage immediately (asynchronous). The first capture occurs on the first rising edge after deassertion.
- Latency: an instruction presented with `in_valid` at edge N appears on the outputs after edge N+STAGES-1, i.e. STAGES edges including capture, plus one extra edge per stalled cycle.
- `ld_hazard` is combinational from stage-0 registers and `rs1`/`rs2`. It is valid in the cycle after a load is captured and is held while stalled.
- There are no combinational paths from `instruction` to any `wb_*` output.

## Configuration
- `WB_CSR_EN` defined: SYSTEM with funct3 != 000 (CSRRW..CSRRCI) -> sel 11, we 1 (subject to the rd == 0 rule). ECALL/EBREAK/MRET (funct3 000) -> we 0.
- Undefined: all SYSTEM -> sel 00, we 0. Encoding 11 is never produced.

## Structure
- Package `wb_pkg`:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM);
  - WB_SEL_MEM/ALU/PC4/CSR;
  - the `wb_bundle_t` struct.
- Sub-module `wb_decode`: purely combinational decode of instruction -> `wb_bundle_t`, instantiated once.
- `wb_ctl_pipe` contains only the stage registers, stall/flush control and the hazard compare.

## Test plan
- Reset then idle, STAGES=3 -> all outputs 0. Assert rst mid-stream with 3 valid instructions in flight -> `wb_valid`=0 immediately, nothing emitted afterward.
- Issue ADDI x5 (0x00500293) at edge 0 -> at edge 2 outputs `wb_valid`=1, sel=01, we=1, rd=5. JAL x1 -> sel=10, rd=1. LW x0 -> we=0.
- Issue LW x7 then decode rs1=7 -> `ld_hazard`=1 for one cycle. rs1=0 with LW x0 -> `ld_hazard`=0.
- Hold `stall` for 4 cycles with 3 live stages -> outputs frozen; after release, the order and spacing of the sequence are preserved.
- Fill 3 stages, assert `flush` together with `stall` -> the last stage is held, younger stages are emptied, and only one instruction retires.
- Opcode 0x7F -> `wb_illegal`=1, we=0. CSRRW x3 -> sel=11, we=1 with `WB_CSR_EN`; sel=00, we=0 without it.
